// File: rtl/clint_hart_int_ctrl_if.sv
// Pipeline-side interrupt handshake between the hart interrupt controller and the core.
// Ports: int_req/int_cause (controller -> pipeline), int_ack/mret (pipeline -> controller).
// The master modport is the controller; the slave modport is the pipeline.
interface clint_hart_int_ctrl_if;
  logic       int_req;    // interrupt request, held while a request is outstanding
  logic [3:0] int_cause;  // mcause code of the requested interrupt (3, 7 or 11)
  logic       int_ack;    // pipeline takes the trap
  logic       mret;       // one-cycle pulse: handler returned

  modport master (
    output int_req,
    output int_cause,
    input  int_ack,
    input  mret
  );

  modport slave (
    input  int_req,
    input  int_cause,
    output int_ack,
    output mret
  );
endinterface

// File: rtl/clint_hart_int_ctrl.sv
// Hart-side CLINT interrupt receiver: keeps MSIP/MTIP/MEIP, applies enables, arbitrates
// MEI > MSI > MTI and raises one request per trap; int_req follows the pending bit by one edge.
// Backpressure: a request is held until int_ack, or withdrawn if its source stops being eligible.
//
// Ports:
//   clk, n_rst                        clock, asynchronous active-low reset
//   timer_int / clear_timer_int       CLINT pulses that set / clear MTIP (set wins)
//   soft_int / clear_soft_int         CLINT pulses that set / clear MSIP (clear wins)
//   ext_int                           asynchronous level, synchronized into MEIP
//   mstatus_mie, mie_msie/mtie/meie   global and per-source enables
//   pipe (master)                     int_req/int_cause out, int_ack/mret in
//   mip_rdata                         mip CSR readback
//   last_latency                      req-to-ack cycle count of the last taken interrupt
// Optional build macro CLINT_HART_INT_LATENCY_EN: when defined, a saturating latency counter
// drives last_latency; otherwise last_latency is tied to 0 and no counter exists.
module clint_hart_int_ctrl #(
  parameter int EXT_SYNC_STAGES = 2,  // must be at least 2
  parameter int LAT_W           = 16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      timer_int,
  input  logic                      clear_timer_int,
  input  logic                      soft_int,
  input  logic                      clear_soft_int,
  input  logic                      ext_int,
  input  logic                      mstatus_mie,
  input  logic                      mie_msie,
  input  logic                      mie_mtie,
  input  logic                      mie_meie,
  clint_hart_int_ctrl_if.master     pipe,
  output logic [31:0]               mip_rdata,
  output logic [LAT_W-1:0]          last_latency
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  logic [EXT_SYNC_STAGES-1:0] ext_sync_q;
  logic                       msip_q, msip_d;
  logic                       mtip_q, mtip_d;
  logic                       meip;
  logic [1:0]                 state_q, state_d;
  logic [3:0]                 cause_q, cause_d;
  logic [2:0]                 eligible;      // {MEI, MTI, MSI}
  logic                       any_eligible;
  logic                       src_eligible;  // source latched in cause_q is still eligible
  logic [3:0]                 arb_cause;

  // ext_int is asynchronous; MEIP is simply the last synchronizer stage, never latched.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ext_sync_q <= '0;
    end else begin
      ext_sync_q <= {ext_sync_q[EXT_SYNC_STAGES-2:0], ext_int};
    end
  end

  assign meip = ext_sync_q[EXT_SYNC_STAGES-1];

  // A timer compare and a mtimecmp write in the same cycle leave the timer pending;
  // an msip write of 0 beats a concurrent msip write of 1.
  always_comb begin
    mtip_d = mtip_q;
    if (timer_int) begin
      mtip_d = 1'b1;
    end else if (clear_timer_int) begin
      mtip_d = 1'b0;
    end

    msip_d = msip_q;
    if (clear_soft_int) begin
      msip_d = 1'b0;
    end else if (soft_int) begin
      msip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mtip_q <= 1'b0;
      msip_q <= 1'b0;
    end else begin
      mtip_q <= mtip_d;
      msip_q <= msip_d;
    end
  end

  always_comb begin
    mip_rdata     = '0;
    mip_rdata[11] = meip;
    mip_rdata[7]  = mtip_q;
    mip_rdata[3]  = msip_q;
  end

  assign eligible     = {3{mstatus_mie}} & {meip, mtip_q, msip_q} & {mie_meie, mie_mtie, mie_msie};
  assign any_eligible = |eligible;

  always_comb begin
    arb_cause = CAUSE_MTI;
    if (eligible[2]) begin
      arb_cause = CAUSE_MEI;
    end else if (eligible[0]) begin
      arb_cause = CAUSE_MSI;
    end
  end

  always_comb begin
    case (cause_q)
      CAUSE_MEI: src_eligible = eligible[2];
      CAUSE_MTI: src_eligible = eligible[1];
      CAUSE_MSI: src_eligible = eligible[0];
      default:   src_eligible = 1'b0;
    endcase
  end

  // The cause is captured only when leaving IDLE, so a request never changes its cause
  // while int_req is high. An ack in the same cycle as a withdraw condition still takes the trap.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          state_d = ST_REQ;
          cause_d = arb_cause;
        end
      end
      ST_REQ: begin
        if (pipe.int_ack) begin
          state_d = ST_HANDLER;
        end else if (!src_eligible) begin
          state_d = ST_IDLE;
        end
      end
      ST_HANDLER: begin
        if (pipe.mret) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cause_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign pipe.int_req   = (state_q == ST_REQ);
  assign pipe.int_cause = cause_q;

`ifdef CLINT_HART_INT_LATENCY_EN
  localparam logic [LAT_W-1:0] LAT_ONE = 1;

  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0] last_lat_q, last_lat_d;
  logic [LAT_W-1:0] lat_cnt_inc;

  // Saturating increment; the ack cycle itself counts, hence last_latency = counter + 1.
  assign lat_cnt_inc = (&lat_cnt_q) ? lat_cnt_q : (lat_cnt_q + LAT_ONE);

  always_comb begin
    lat_cnt_d  = lat_cnt_q;
    last_lat_d = last_lat_q;
    if (state_q == ST_IDLE) begin
      if (any_eligible) begin
        lat_cnt_d = '0;
      end
    end else if (state_q == ST_REQ) begin
      lat_cnt_d = lat_cnt_inc;
      if (pipe.int_ack) begin
        last_lat_d = lat_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lat_cnt_q  <= '0;
      last_lat_q <= '0;
    end else begin
      lat_cnt_q  <= lat_cnt_d;
      last_lat_q <= last_lat_d;
    end
  end

  assign last_latency = last_lat_q;
`else
  assign last_latency = '0;
`endif

endmodule

// File: tb/tb_clint_hart_int_ctrl.sv
module tb_clint_hart_int_ctrl;
  localparam int N_SYNC  = 2;
  localparam int LW      = 16;
  localparam int LAT_MAX = (1 << LW) - 1;

  logic clk = 1'b0;
  logic n_rst;
  logic timer_int, clear_timer_int, soft_int, clear_soft_int, ext_int;
  logic mstatus_mie, mie_msie, mie_mtie, mie_meie;
  logic [31:0]   mip_rdata;
  logic [LW-1:0] last_latency;

  clint_hart_int_ctrl_if pipe_if ();

  clint_hart_int_ctrl #(.EXT_SYNC_STAGES(N_SYNC), .LAT_W(LW)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .timer_int       (timer_int),
    .clear_timer_int (clear_timer_int),
    .soft_int        (soft_int),
    .clear_soft_int  (clear_soft_int),
    .ext_int         (ext_int),
    .mstatus_mie     (mstatus_mie),
    .mie_msie        (mie_msie),
    .mie_mtie        (mie_mtie),
    .mie_meie        (mie_meie),
    .pipe            (pipe_if.master),
    .mip_rdata       (mip_rdata),
    .last_latency    (last_latency)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending flags, external-level history, and a "where is the trap" view.
  bit m_msip, m_mtip;
  bit m_hist [N_SYNC];   // m_hist[0] = most recently sampled ext_int
  bit m_req, m_hdl;
  int m_cause, m_req_cycles, m_last;

  task automatic model_reset();
    m_msip = 0; m_mtip = 0; m_req = 0; m_hdl = 0;
    m_cause = 0; m_req_cycles = 0; m_last = 0;
    for (int i = 0; i < N_SYNC; i++) m_hist[i] = 0;
  endtask

  task automatic model_edge();
    bit [2:0] elig;
    bit src_ok;
    elig = mstatus_mie ? ({m_hist[N_SYNC-1], m_mtip, m_msip} & {mie_meie, mie_mtie, mie_msie}) : 3'b000;
    if (m_req) begin
      src_ok = (m_cause == 11) ? elig[2] : (m_cause == 7) ? elig[1] : elig[0];
      m_req_cycles++;
      if (pipe_if.int_ack) begin
        m_req = 0; m_hdl = 1;
        m_last = (m_req_cycles > LAT_MAX) ? LAT_MAX : m_req_cycles;
      end else if (!src_ok) begin
        m_req = 0;
      end
    end else if (m_hdl) begin
      if (pipe_if.mret) m_hdl = 0;
    end else if (elig != 0) begin
      m_req = 1; m_req_cycles = 0;
      m_cause = elig[2] ? 11 : (elig[0] ? 3 : 7);
    end
    if (timer_int) m_mtip = 1; else if (clear_timer_int) m_mtip = 0;
    if (clear_soft_int) m_msip = 0; else if (soft_int) m_msip = 1;
    for (int i = N_SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = ext_int;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_mip();
    return (32'(m_hist[N_SYNC-1]) << 11) | (32'(m_mtip) << 7) | (32'(m_msip) << 3);
  endfunction

  function automatic logic [31:0] exp_lat();
`ifdef CLINT_HART_INT_LATENCY_EN
    return 32'(m_last);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".req"},   32'(pipe_if.int_req),   32'(m_req));
    chk({tag, ".cause"}, 32'(pipe_if.int_cause), 32'(m_cause));
    chk({tag, ".mip"},   mip_rdata,              exp_mip());
    chk({tag, ".lat"},   32'(last_latency),      exp_lat());
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs are compared 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (!n_rst) model_reset(); else model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic pulses_low();
    timer_int = 0; clear_timer_int = 0; soft_int = 0; clear_soft_int = 0;
    pipe_if.int_ack = 0; pipe_if.mret = 0;
  endtask

  initial begin
    n_rst = 0; ext_int = 0;
    mstatus_mie = 0; mie_msie = 0; mie_mtie = 0; mie_meie = 0;
    pulses_low();
    model_reset();

    // Reset state
    step("rst0");
    step("rst1");
    chk("rst_mip", mip_rdata, 32'h0);
    n_rst = 1;
    step("rel");

    // Timer interrupt end to end: pulse in cycle 0, ack in cycle 4
    mstatus_mie = 1; mie_mtie = 1;
    timer_int = 1;
    step("t_c1"); timer_int = 0;
    chk("t_mip_c1", mip_rdata, 32'h80);
    chk("t_noreq_c1", 32'(pipe_if.int_req), 32'd0);
    step("t_c2");
    chk("t_req_c2", 32'(pipe_if.int_req), 32'd1);
    chk("t_cause_c2", 32'(pipe_if.int_cause), 32'd7);
    step("t_c3");
    step("t_c4");
    pipe_if.int_ack = 1;
    step("t_c5"); pipe_if.int_ack = 0;
    chk("t_noreq_c5", 32'(pipe_if.int_req), 32'd0);
`ifdef CLINT_HART_INT_LATENCY_EN
    chk("t_lat", 32'(last_latency), 32'd3);
`else
    chk("t_lat", 32'(last_latency), 32'd0);
`endif
    step("t_hdl");
    chk("t_hdl_noreq", 32'(pipe_if.int_req), 32'd0);
    pipe_if.mret = 1;
    step("t_mret"); pipe_if.mret = 0;
    chk("t_idle_gap", 32'(pipe_if.int_req), 32'd0);
    step("t_rereq");
    chk("t_rereq", 32'(pipe_if.int_req), 32'd1);

    // Withdraw: source cleared while requesting, no ack
    clear_timer_int = 1;
    step("wd_clr"); clear_timer_int = 0;
    chk("wd_mip", mip_rdata, 32'h0);
    step("wd_drop");
    chk("wd_drop", 32'(pipe_if.int_req), 32'd0);
    step("wd_idle");

    // Ack coincides with the withdraw condition: trap is taken
    timer_int = 1;
    step("ov_set"); timer_int = 0;
    step("ov_req");
    clear_timer_int = 1;
    step("ov_clr"); clear_timer_int = 0;
    pipe_if.int_ack = 1;
    step("ov_ack"); pipe_if.int_ack = 0;
    timer_int = 1;
    step("ov_hdl0"); timer_int = 0;
    step("ov_hdl1");
    chk("ov_hdl_noreq", 32'(pipe_if.int_req), 32'd0);
    pipe_if.mret = 1;
    step("ov_mret"); pipe_if.mret = 0;
    step("ov_rereq");
    clear_timer_int = 1;
    step("ov_clr2"); clear_timer_int = 0;
    step("ov_idle0");
    step("ov_idle1");

    // Same-cycle set/clear
    mstatus_mie = 0;
    timer_int = 1; clear_timer_int = 1; soft_int = 1; clear_soft_int = 1;
    step("sc_both");
    pulses_low();
    chk("sc_mip", mip_rdata, 32'h80);
    clear_timer_int = 1;
    step("sc_clean"); clear_timer_int = 0;

    // All sources pending with the global enable off, then MEI wins arbitration
    mie_msie = 1; mie_mtie = 1; mie_meie = 1;
    soft_int = 1; timer_int = 1; ext_int = 1;
    step("pr_set"); soft_int = 0; timer_int = 0;
    step("pr_s1");
    step("pr_s2");
    chk("pr_mip", mip_rdata, 32'h888);
    chk("pr_noreq", 32'(pipe_if.int_req), 32'd0);
    mstatus_mie = 1;
    step("pr_en");
    chk("pr_cause11", 32'(pipe_if.int_cause), 32'd11);
    pipe_if.int_ack = 1;
    step("pr_ack"); pipe_if.int_ack = 0;
    ext_int = 0;
    step("pr_x0");
    step("pr_x1");
    step("pr_x2");
    pipe_if.mret = 1;
    step("pr_mret"); pipe_if.mret = 0;
    step("pr_rereq");
    chk("pr_cause3", 32'(pipe_if.int_cause), 32'd3);
    pipe_if.int_ack = 1;
    step("pr_ack2"); pipe_if.int_ack = 0;
    clear_soft_int = 1; clear_timer_int = 1;
    step("pr_clr"); pulses_low();
    pipe_if.mret = 1;
    step("pr_mret2"); pipe_if.mret = 0;
    step("pr_idle");
    mie_msie = 0; mie_meie = 0;

    // Asynchronous reset in the middle of a timer request
    timer_int = 1;
    step("ar_set"); timer_int = 0;
    step("ar_req");
    chk("ar_req_cause", 32'(pipe_if.int_cause), 32'd7);
    #2;
    n_rst = 0;
    #1;
    model_reset();
    check_all("ar_async");
    step("ar_hold");
    n_rst = 1;
    step("ar_rel");
    step("ar_idle");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      timer_int       = ($urandom_range(0, 9) == 0);
      clear_timer_int = ($urandom_range(0, 11) == 0);
      soft_int        = ($urandom_range(0, 9) == 0);
      clear_soft_int  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0)  ext_int     = ~ext_int;
      if ($urandom_range(0, 15) == 0) mstatus_mie = ~mstatus_mie;
      if ($urandom_range(0, 15) == 0) mie_msie    = ~mie_msie;
      if ($urandom_range(0, 15) == 0) mie_mtie    = ~mie_mtie;
      if ($urandom_range(0, 15) == 0) mie_meie    = ~mie_meie;
      pipe_if.int_ack = ($urandom_range(0, 3) == 0);
      pipe_if.mret    = ($urandom_range(0, 5) == 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clint_hart_int_ctrl.md
Name: clint_hart_int_ctrl

Overview:
Hart-side receiver for the CLINT interrupt interface, plus one external interrupt line. Consumes the CLINT set/clear pulses (timer, software) and a level external interrupt, and maintains the MSIP/MTIP/MEIP pending bits. Applies the mie/mstatus.MIE enables and arbitrates by RISC-V priority. Presents one interrupt request with a cause code to the pipeline over a req/ack handshake, then tracks handler residency until mret.

Parameters:
EXT_SYNC_STAGES, 2, number of synchronizer flops on ext_int (minimum 2)
LAT_W, 16, width of the latency counter (used only with the optional feature)

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
timer_int  input  1  one-cycle pulse from the CLINT: timer compare rising edge
clear_timer_int  input  1  one-cycle pulse from the CLINT: mtimecmp/mtimecmph written
soft_int  input  1  one-cycle pulse from the CLINT: msip written with bit0=1
clear_soft_int  input  1  one-cycle pulse from the CLINT: msip written with bit0=0
ext_int  input  1  asynchronous level external interrupt
mstatus_mie  input  1  global machine interrupt enable
mie_msie  input  1  software interrupt enable
mie_mtie  input  1  timer interrupt enable
mie_meie  input  1  external interrupt enable
int_ack  input  1  pipeline accepts the request (trap taken)
mret  input  1  one-cycle pulse: handler returned
int_req  output  1  interrupt request to the pipeline
int_cause  output  4  cause code: 3 (MSI), 7 (MTI) or 11 (MEI)
mip_rdata  output  32  mip CSR readback
last_latency  output  LAT_W  cycles from req to ack (optional feature only)

Behaviour:
- Reset: state=IDLE; int_req=0; int_cause=0; MSIP=MTIP=0; sync flops=0; mip_rdata=0; last_latency=0.
- MEIP = output of the EXT_SYNC_STAGES-flop synchronizer on ext_int. MEIP is level-tracking, not latched.
- MTIP (register):
  - Set on timer_int; cleared on clear_timer_int.
  - Both asserted in the same cycle: set wins (MTIP=1).
- MSIP (register):
  - Set on soft_int; cleared on clear_soft_int.
  - Both asserted in the same cycle: clear wins.
- Pending bits update at the clock edge that samples the pulse.
- mip_rdata: bit11=MEIP, bit7=MTIP, bit3=MSIP; all other bits 0. Combinational from the pending registers.
- eligible = mstatus_mie & ({MEIP,MTIP,MSIP} & {meie,mtie,msie}).
- Priority: MEI > MSI > MTI.
- FSM:
  - IDLE: if any eligible bit is set, go to REQ at the next edge and register int_cause from the highest-priority eligible source.
  - REQ: int_req=1; int_cause held stable and not re-arbitrated, even if a higher-priority source arrives.
    - int_ack=1 -> HANDLER.
    - Latched source no longer eligible (cleared, disabled, or mstatus_mie=0) and int_ack=0 -> IDLE (withdraw). int_ack in the same cycle overrides the withdraw.
  - HANDLER: int_req=0; pending bits keep updating. mret -> IDLE.
  - mret in IDLE or REQ is ignored.
- int_req = (state==REQ), registered. int_cause holds its last value outside REQ.
- Latency: pulse sampled at edge E0 -> pending set at E0 -> int_req high after E1 (one cycle after the pending bit).
- After mret, at least one cycle is spent in IDLE before the next int_req.
- Pending bits are never cleared by int_ack; clearing comes only from the CLINT pulses or ext_int deassertion.

Optional Feature:
- Macro: CLINT_HART_INT_LATENCY_EN.
- Defined:
  - An LAT_W counter resets to 0 on entry to REQ and increments each REQ cycle, saturating at all-ones.
  - On int_ack, last_latency <= counter+1 (also saturating). last_latency holds its value until the next ack.
  - A withdraw does not update last_latency.
- Undefined: no counter is built and last_latency is tied to 0.

Test Plan:
- Reset mid-REQ (int_req=1, cause=7), assert n_rst=0 -> int_req=0, int_cause=0, mip_rdata=0 immediately (async); state IDLE after release.
- mie_mtie=1, mstatus_mie=1, timer_int pulse at cycle 0, int_ack at cycle 4 -> mip_rdata=0x80 from cycle 1; int_req=1 with int_cause=7 cycles 2-4; int_req=0 from cycle 5; second int_req only after mret plus one IDLE cycle. With the macro defined: last_latency=3.
- All enables=1; soft_int pulse and ext_int high in the same cycle -> MSIP visible first; MEI must win once MEIP resolves through 2 sync flops before arbitration. Precisely: MSIP and MEIP both pending at the IDLE arbitration edge -> int_cause=11. After mret with MSIP still set -> new req with int_cause=3.
- In REQ with cause=7, clear_timer_int pulse and int_ack=0 -> int_req drops at the next edge, state IDLE, mip_rdata bit7=0. Repeat with int_ack=1 in the same cycle -> HANDLER, no withdraw.
- timer_int and clear_timer_int in the same cycle -> MTIP=1. soft_int and clear_soft_int in the same cycle -> MSIP=0.
- mstatus_mie=0, all sources pending (mip_rdata=0x888) -> int_req stays 0. Set mstatus_mie=1 -> int_req=1, int_cause=11 one edge later.
